// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache: access-width codes, address-split
// width helpers, the LRU age type and byte/half/word lane helpers.
package cache_pkg;

  localparam logic [2:0] UBHW_LB  = 3'b000;
  localparam logic [2:0] UBHW_LH  = 3'b001;
  localparam logic [2:0] UBHW_LW  = 3'b010;
  localparam logic [2:0] UBHW_LBU = 3'b100;
  localparam logic [2:0] UBHW_LHU = 3'b101;

  // Wide enough for the largest supported associativity (8 ways).
  localparam int AGE_MAX_W = 3;
  typedef logic [AGE_MAX_W-1:0] age_t;

  function automatic int word_bits_f(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits_f(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits_f(input int addr_bits, input int sets, input int line_words);
    return addr_bits - 2 - word_bits_f(line_words) - index_bits_f(sets);
  endfunction

  function automatic logic [31:0] lane_extract_f(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  ubhw);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half   = off[1] ? word[31:16] : word[15:0];
    byte_v = word[{off, 3'b000} +: 8];
    if (ubhw[1]) begin
      res = word;
    end else if (ubhw[0]) begin
      res = ubhw[2] ? {16'h0000, half} : {{16{half[15]}}, half};
    end else begin
      res = ubhw[2] ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
    end
    return res;
  endfunction

  function automatic logic [31:0] lane_merge_f(input logic [31:0] old,
                                               input logic [31:0] din,
                                               input logic [1:0]  off,
                                               input logic [2:0]  ubhw);
    logic [31:0] res;
    res = old;
    if (ubhw[1]) begin
      res = din;
    end else if (ubhw[0]) begin
      res = off[1] ? {din[15:0], old[15:0]} : {old[31:16], din[15:0]};
    end else begin
      res[{off, 3'b000} +: 8] = din[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU logic: picks the hit / first-invalid / oldest way and
// computes the age vector after promoting the hitting way to most recent.
module cache_lru
  import cache_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int AW   = $clog2(WAYS)
) (
  input  logic [WAYS*AW-1:0] ages_i,
  input  logic [WAYS-1:0]    valid_i,
  input  logic [WAYS-1:0]    hit_i,
  output logic [WAYS*AW-1:0] ages_o,
  output logic [AW-1:0]      sel_o,
  output logic               hit_o
);

  logic [AW-1:0] hit_idx_s;
  logic [AW-1:0] inv_idx_s;
  logic [AW-1:0] old_idx_s;
  logic          inv_any_s;
  age_t          hit_age_s;

  // Locate the hitting way, the lowest invalid way and the oldest way.
  always_comb begin
    hit_idx_s = {AW{1'b0}};
    inv_idx_s = {AW{1'b0}};
    old_idx_s = {AW{1'b0}};
    hit_age_s = {AGE_MAX_W{1'b0}};
    hit_o     = |hit_i;
    inv_any_s = ~&valid_i;
    for (int w = 0; w < WAYS; w++) begin
      hit_idx_s = hit_i[w] ? AW'(w) : hit_idx_s;
      hit_age_s = hit_i[w] ? age_t'(ages_i[w*AW +: AW]) : hit_age_s;
      old_idx_s = (ages_i[w*AW +: AW] == AW'(WAYS-1)) ? AW'(w) : old_idx_s;
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      inv_idx_s = valid_i[w] ? inv_idx_s : AW'(w);
    end
  end

  // Way selection and aging: younger-than-hit ways age by one, hit way becomes 0.
  always_comb begin
    ages_o = ages_i;
    sel_o  = hit_o ? hit_idx_s : (inv_any_s ? inv_idx_s : old_idx_s);
    for (int w = 0; w < WAYS; w++) begin
      ages_o[w*AW +: AW] = (!hit_o) ? ages_i[w*AW +: AW] :
                           hit_i[w] ? {AW{1'b0}} :
                           (age_t'(ages_i[w*AW +: AW]) < hit_age_s) ? ages_i[w*AW +: AW] + AW'(1) :
                           ages_i[w*AW +: AW];
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back cache array with true-LRU replacement
// and a set-by-set flush sequencer; all responses are registered.
module cache_nway
  import cache_pkg::*;
#(
  parameter  int WAYS       = 4,
  parameter  int SETS       = 32,
  parameter  int LINE_WORDS = 4,
  parameter  int ADDR_BITS  = 32,
  localparam int TAG_BITS   = tag_bits_f(ADDR_BITS, SETS, LINE_WORDS),
  localparam int AW         = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 load,
  input  logic                 edit,
  input  logic                 store,
  input  logic                 invalid,
  input  logic                 flush_req,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          din,
  output logic                 hit,
  output logic [31:0]          dout,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_BITS-1:0]  tag,
  output logic [AW-1:0]        victim,
  output logic                 busy,
  output logic                 flush_done
);

  localparam int WW  = word_bits_f(LINE_WORDS);
  localparam int IW  = index_bits_f(SETS);
  localparam int WWS = (WW > 0) ? WW : 1;
  localparam int IWS = (IW > 0) ? IW : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_e;

  function automatic logic [WAYS*AW-1:0] ages_rst_f();
    logic [WAYS*AW-1:0] a;
    a = {(WAYS*AW){1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      a[w*AW +: AW] = AW'(w);
    end
    return a;
  endfunction

  localparam logic [WAYS*AW-1:0] AGES_RST = ages_rst_f();

  logic [31:0]         data_q  [SETS][WAYS][LINE_WORDS];
  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAYS*AW-1:0]  ages_q  [SETS];

  state_e         state_q, state_d;
  logic [IWS-1:0] cnt_q, cnt_d;
  logic           done_d;

  logic                hit_q, valid_o_q, dirty_o_q, done_q;
  logic [31:0]         dout_q;
  logic [TAG_BITS-1:0] tag_o_q;
  logic [AW-1:0]       victim_q;

  logic [IWS-1:0]      index_s;
  logic [WWS-1:0]      word_s;
  logic [1:0]          off_s;
  logic [TAG_BITS-1:0] addr_tag_s;
  logic [WAYS-1:0]     hit_vec_s;
  logic [WAYS*AW-1:0]  ages_next_s;
  logic [AW-1:0]       sel_s;
  logic                hit_any_s;
  logic [31:0]         sel_word_s;
  logic                cmd_en_s, do_inv_s, do_store_s, do_edit_s, do_load_s;
  logic                clr_en_s;
  logic [IWS-1:0]      clr_set_s;

  assign index_s    = IWS'(addr >> (2 + WW));
  assign word_s     = WWS'(addr >> 2);
  assign off_s      = addr[1:0];
  assign addr_tag_s = TAG_BITS'(addr >> (2 + WW + IW));

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_vec_s = {WAYS{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_q[index_s][w] & (tag_q[index_s][w] == addr_tag_s);
    end
  end

  cache_lru #(.WAYS(WAYS)) u_lru (
    .ages_i  (ages_q[index_s]),
    .valid_i (valid_q[index_s]),
    .hit_i   (hit_vec_s),
    .ages_o  (ages_next_s),
    .sel_o   (sel_s),
    .hit_o   (hit_any_s)
  );

  assign sel_word_s = data_q[index_s][sel_s][word_s];

  // One command per cycle, invalid > store > edit > load; none while flushing.
  always_comb begin
    cmd_en_s   = rst & (state_q == ST_IDLE);
    do_inv_s   = cmd_en_s & invalid;
    do_store_s = cmd_en_s & ~invalid & store;
    do_edit_s  = cmd_en_s & ~invalid & ~store & edit & hit_any_s;
    do_load_s  = cmd_en_s & ~invalid & ~store & ~edit & load;
    clr_en_s   = do_inv_s | (state_q == ST_FLUSH);
    clr_set_s  = (state_q == ST_FLUSH) ? cnt_q : index_s;
  end

  // Flush sequencer next state: walk every set once, then pulse done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = {IWS{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + IWS'(1);
        if (cnt_q == IWS'(SETS-1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Flush sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {IWS{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data and tag arrays carry no reset; only the metadata says they are live.
  always_ff @(posedge clk) begin
    if (do_store_s) begin
      data_q[index_s][sel_s][word_s] <= din;
      tag_q[index_s][sel_s]          <= addr_tag_s;
    end else if (do_edit_s) begin
      data_q[index_s][sel_s][word_s] <= lane_merge_f(sel_word_s, din, off_s, u_b_h_w);
    end
  end

  // Valid, dirty and age metadata.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= {WAYS{1'b0}};
        dirty_q[s] <= {WAYS{1'b0}};
        ages_q[s]  <= AGES_RST;
      end
    end else if (clr_en_s) begin
      valid_q[clr_set_s] <= {WAYS{1'b0}};
      dirty_q[clr_set_s] <= {WAYS{1'b0}};
      ages_q[clr_set_s]  <= AGES_RST;
    end else if (do_store_s) begin
      valid_q[index_s][sel_s] <= 1'b1;
      dirty_q[index_s][sel_s] <= 1'b0;
    end else if (do_edit_s) begin
      dirty_q[index_s][sel_s] <= 1'b1;
      ages_q[index_s]         <= ages_next_s;
    end else if (do_load_s & hit_any_s) begin
      ages_q[index_s] <= ages_next_s;
    end
  end

  // Registered responses describing the selected way of the current lookup.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q     <= 1'b0;
      dout_q    <= 32'h0000_0000;
      valid_o_q <= 1'b0;
      dirty_o_q <= 1'b0;
      tag_o_q   <= {TAG_BITS{1'b0}};
      victim_q  <= {AW{1'b0}};
      done_q    <= 1'b0;
    end else begin
      hit_q     <= (state_q == ST_IDLE) & hit_any_s;
      valid_o_q <= valid_q[index_s][sel_s];
      dirty_o_q <= dirty_q[index_s][sel_s];
      tag_o_q   <= tag_q[index_s][sel_s];
      victim_q  <= sel_s;
      done_q    <= done_d;
      if (state_q == ST_FLUSH) begin
        dout_q <= dout_q;
      end else if (do_load_s) begin
        dout_q <= hit_any_s ? lane_extract_f(sel_word_s, off_s, u_b_h_w) : dout_q;
      end else begin
        dout_q <= sel_word_s;
      end
    end
  end

  assign hit        = hit_q;
  assign dout       = dout_q;
  assign valid      = valid_o_q;
  assign dirty      = dirty_o_q;
  assign tag        = tag_o_q;
  assign victim     = victim_q;
  assign busy       = (state_q == ST_FLUSH);
  assign flush_done = done_q;

endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative, write-back data cache array with true-LRU replacement and a built-in multi-cycle flush sequencer. It generalises the existing 2-way cache:
- way count, set count and line size are parameters;
- the 1-bit recent flag is replaced by per-way age counters;
- reset and cache-wide invalidation are sequential.

It sits between the CPU load/store path and the cache controller FSM, which drives `load`/`edit`/`store` and performs memory transfers.

## Interface
- `WAYS`, 4: associativity; power of 2, 2..8.
- `SETS`, 32: number of sets; power of 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of 2.
- `ADDR_BITS`, 32: address width.
- `TAG_BITS`, derived: `ADDR_BITS - 2 - log2(LINE_WORDS) - log2(SETS)`. Equals 23 at defaults.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `addr`  in  ADDR_BITS  address, split as `{tag, index, word, byte[1:0]}`.
- `load`  in  1  CPU read; updates LRU on hit.
- `edit`  in  1  CPU write on hit; sets dirty.
- `store`  in  1  memory-to-cache word fill.
- `invalid`  in  1  invalidate all ways of the addressed set.
- `flush_req`  in  1  start whole-cache invalidation.
- `u_b_h_w`  in  3  RV32I width/sign code: bit1 = word, bit0 = half, bit2 = unsigned.
- `din`  in  32  write data.
- `hit`  out  1  registered hit flag.
- `dout`  out  32  registered read data.
- `valid`, `dirty`  out  1  registered flags of the selected way.
- `tag`  out  TAG_BITS  registered tag of the selected way.
- `victim`  out  log2(WAYS)  registered index of the selected way.
- `busy`  out  1  flush in progress.
- `flush_done`  out  1  one-cycle pulse when the flush completes.

## Operation
- Lookup: `hit_w = valid[set][w] & (tag[set][w] == addr_tag)`. At most one way hits.
- Selected way:
  - the hitting way if any;
  - otherwise the lowest-index invalid way;
  - otherwise the way with age == `WAYS-1`.
  - `valid`/`dirty`/`tag`/`victim` report this way every cycle.
- LRU ages:
  - Each way holds a log2(WAYS)-bit age; 0 = most recent.
  - Ages within a set are always a permutation of `0..WAYS-1`.
  - On a load/edit hit to way h: every way with age < age[h] increments, then age[h] = 0.
- `load`, hit:
  - `dout` = word, sign/zero-extended half, or byte per `u_b_h_w`, using `addr[1:0]`.
  - LRU is updated.
- `load`, miss: `dout` and LRU unchanged.
- `load` low: `dout` = word `addr.word` of the selected way (writeback path); no LRU change.
- `edit`, hit: merge `din` into the word at the byte/half/word lane; dirty = 1; LRU updated. On a miss, `edit` has no effect.
- `store`: write `din` whole into word `addr.word` of the selected way; set that way's tag = `addr_tag`, valid = 1, dirty = 0; LRU not updated.
  - Consecutive fills of the same line hit the same way.
- `invalid`: clear valid and dirty of all ways in the set; ages reset to way index.
- Command priority when several are asserted: `invalid` > `store` > `edit` > `load`.
- Flush FSM:
  - IDLE: on `flush_req` → FLUSH, set counter = 0.
  - FLUSH: each cycle apply `invalid` to set `counter` and increment. After set `SETS-1` → IDLE with `flush_done` pulsed.
  - While `busy`: all commands and `flush_req` are ignored; `hit` = 0.

## Timing
- All outputs are registered: responses appear on the edge after the command.
- Array writes commit on the same edge. A command in cycle t+1 sees the effect of cycle t (no stale read).
- `busy` rises the cycle after `flush_req`.
- Flush lasts exactly `SETS` cycles; `flush_done` is high in the first cycle `busy` is low again.
- Reset (`rst`=0 at an edge):
  - valid, dirty and LRU of every set cleared, ages = way index;
  - FSM → IDLE;
  - all outputs 0;
  - data and tag arrays are not cleared.
  - Reset mid-flush aborts the flush with no `flush_done`.
- `flush_req` asserted together with a command in IDLE: the command executes, then the flush starts.

## Structure
- Package `cache_pkg`: `u_b_h_w` encodings; address-split width functions; LRU age type.
- Sub-module `cache_lru`, combinational, per set:
  - inputs: ages vector, valid vector, hit vector;
  - outputs: next ages, selected way.
- Top: storage arrays, lane merge/extract, flush FSM, output registers.

## Test plan
- After reset: store four words of tag 0x1, set 3 → load LW each word: `hit`=1, data matches, `victim`=0.
- `edit` SB 0xAB at byte 2 of a word holding 0x11223344 → load LW returns 0x11AB3344, `dirty`=1. Then LB returns 0xFFFFFFAB; LBU returns 0x000000AB.
- LRU at WAYS=4:
  - fill ways 0..3 of set 5, then load ways 0, 2, 1 → victim = 3;
  - load way 3 → victim = 0.
- Miss on a full set with dirty victim, `load`=0 → `dout` = victim word, `dirty`=1, `tag` = old tag.
- `flush_req` at SETS=32:
  - `busy` high for 32 cycles, then `flush_done` pulse;
  - all subsequent loads miss;
  - a `load` during `busy` gives `hit`=0 with no state change.
- `rst` low at flush cycle 10 → `busy`=0 next cycle, no `flush_done`, all outputs 0.
